// File: rtl/key_tone_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_tone_pkg
// Purpose  : Shared types, key codes and note frequency table for the
//            keypad/song tone scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package key_tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_KEY_PLAY  = 2'd1,
        ST_SONG_PLAY = 2'd2,
        ST_SONG_GAP  = 2'd3
    } state_e;

    localparam logic [3:0] NOTE_MAX     = 4'd13;
    localparam logic [3:0] CODE_SILENCE = 4'd14;
    localparam logic [3:0] CODE_SONG    = 4'd15;

    // C4..B5 diatonic; codes above NOTE_MAX are rests (0 Hz)
    function automatic int note_hz(input logic [3:0] n);
        case (n)
            4'd0:    return 262;
            4'd1:    return 294;
            4'd2:    return 330;
            4'd3:    return 349;
            4'd4:    return 392;
            4'd5:    return 440;
            4'd6:    return 494;
            4'd7:    return 523;
            4'd8:    return 587;
            4'd9:    return 659;
            4'd10:   return 698;
            4'd11:   return 784;
            4'd12:   return 880;
            4'd13:   return 988;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] note_div(input logic [3:0] n, input int clk_hz);
        int hz;
        hz = note_hz(n);
        if (hz == 0) begin
            return 32'd0;
        end
        return 32'(clk_hz / (2 * hz));
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_tone_fifo.sv
`default_nettype none
// ============================================================================
// Module   : key_tone_fifo
// Purpose  : 4-entry x 4-bit synchronous FIFO holding queued key note codes.
// Revision : 1.0 - initial release
// ============================================================================
module key_tone_fifo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_flush,
    input  logic       i_push,
    input  logic [3:0] i_din,
    input  logic       i_pop,
    output logic [3:0] o_dout,
    output logic       o_full,
    output logic       o_empty
);

    logic [3:0] mem_q [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       w_push_ok;
    logic       w_pop_ok;

    assign o_full    = (cnt_q == 3'd4);
    assign o_empty   = (cnt_q == 3'd0);
    assign o_dout    = mem_q[rd_ptr_q];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (i_flush) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            cnt_d    = 3'd0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_d = wr_ptr_q + 2'd1;
            end
            if (w_pop_ok) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   cnt_d = cnt_q + 3'd1;
                2'b01:   cnt_d = cnt_q - 3'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (w_push_ok && !i_flush) begin
                mem_q[wr_ptr_q] <= i_din;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_tone_sched.sv
`default_nettype none
// ============================================================================
// Module   : key_tone_sched
// Purpose  : Arbitrates the shared tone divider between live keypad notes and
//            an auto-play song reader; owns hold, note-length and gap timing.
//            Define KEY_QUEUE_EN to queue up to 4 keypad notes during a hold.
// Revision : 1.0 - initial release
// ============================================================================
module key_tone_sched
    import key_tone_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_CYC = CLK_HZ / 1000,
    parameter int KEY_HOLD = 200,
    parameter int GAP      = 20,
    parameter int DIV_W    = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             song_valid,
    input  logic [3:0]       song_note,
    input  logic [11:0]      song_len,
    output logic             song_ready,
    output logic             tone_en,
    output logic [DIV_W-1:0] tone_div,
    output logic             song_on,
    output logic [1:0]       play_src
);

    localparam int              PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);
    localparam logic [11:0]     KEY_LEN  = 12'(KEY_HOLD);
    localparam logic [11:0]     GAP_LEN  = 12'(GAP);

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [11:0]        ticks_q, ticks_d;
    logic [11:0]        len_q, len_d;
    logic               tone_en_q, tone_en_d;
    logic [DIV_W-1:0]   tone_div_q, tone_div_d;
    logic               song_on_q, song_on_d;

    logic               key_note, key_sil, key_tog;
    logic               song_take, tick, expire;
    logic [11:0]        cur_len;
    logic               start_key, end_key, enter;
    logic [3:0]         start_code;
    logic [DIV_W-1:0]   div_tab [16];

    // Constant per-index lookup so no run-time divider is built
    for (genvar g = 0; g < 16; g++) begin : g_div_tab
        assign div_tab[g] = DIV_W'(note_div(4'(g), CLK_HZ));
    end

`ifdef KEY_QUEUE_EN
    logic       q_push, q_pop, q_full, q_empty;
    logic [3:0] q_dout;

    key_tone_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (key_sil),
        .i_push  (q_push),
        .i_din   (key_code),
        .i_pop   (q_pop),
        .o_dout  (q_dout),
        .o_full  (q_full),
        .o_empty (q_empty)
    );
`endif

    assign key_note  = key_valid && (key_code <= NOTE_MAX);
    assign key_sil   = key_valid && (key_code == CODE_SILENCE);
    assign key_tog   = key_valid && (key_code == CODE_SONG);
    assign song_take = rst_n && (state_q == ST_IDLE) && song_on_q && song_valid && !key_valid;
    assign tick      = (pre_q == PRE_LAST);

    always_comb begin
        case (state_q)
            ST_KEY_PLAY:  cur_len = KEY_LEN;
            ST_SONG_PLAY: cur_len = len_q;
            default:      cur_len = GAP_LEN;
        endcase
    end

    assign expire = tick && (ticks_q == cur_len - 12'd1);

    always_comb begin
        state_d    = state_q;
        pre_d      = tick ? '0 : pre_q + PRE_W'(1);
        ticks_d    = tick ? ticks_q + 12'd1 : ticks_q;
        len_d      = len_q;
        tone_en_d  = tone_en_q;
        tone_div_d = tone_div_q;
        song_on_d  = song_on_q;
        start_key  = 1'b0;
        start_code = key_code;
        end_key    = 1'b0;
        enter      = 1'b0;
`ifdef KEY_QUEUE_EN
        q_push     = 1'b0;
        q_pop      = 1'b0;
`endif
        if (key_sil) begin
            state_d   = ST_IDLE;
            tone_en_d = 1'b0;
            song_on_d = 1'b0;
            enter     = 1'b1;
        end else begin
            if (key_tog) begin
                song_on_d = !song_on_q;
            end
            if (key_tog && song_on_q &&
                (state_q == ST_SONG_PLAY || state_q == ST_SONG_GAP)) begin
                state_d   = ST_IDLE;
                tone_en_d = 1'b0;
                enter     = 1'b1;
            end else if (key_note && state_q != ST_KEY_PLAY) begin
                start_key = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (song_take) begin
                            state_d    = ST_SONG_PLAY;
                            len_d      = (song_len == 12'd0) ? 12'd1 : song_len;
                            tone_div_d = div_tab[song_note];
                            tone_en_d  = (song_note <= NOTE_MAX);
                            enter      = 1'b1;
                        end
                    end
                    ST_KEY_PLAY: begin
`ifdef KEY_QUEUE_EN
                        // An empty queue at expiry lets a fresh key start directly
                        if (key_note && !(expire && q_empty)) begin
                            q_push = !q_full;
                        end
                        if (expire) begin
                            if (!q_empty) begin
                                q_pop      = 1'b1;
                                start_key  = 1'b1;
                                start_code = q_dout;
                            end else if (key_note) begin
                                start_key = 1'b1;
                            end else begin
                                end_key = 1'b1;
                            end
                        end
`else
                        if (key_note) begin
                            start_key = 1'b1;
                        end else if (expire) begin
                            end_key = 1'b1;
                        end
`endif
                    end
                    ST_SONG_PLAY: begin
                        if (expire) begin
                            state_d   = ST_SONG_GAP;
                            tone_en_d = 1'b0;
                            enter     = 1'b1;
                        end
                    end
                    default: begin
                        if (expire) begin
                            state_d = ST_IDLE;
                            enter   = 1'b1;
                        end
                    end
                endcase
            end
        end
        if (start_key) begin
            state_d    = ST_KEY_PLAY;
            tone_div_d = div_tab[start_code];
            tone_en_d  = 1'b1;
            enter      = 1'b1;
        end
        if (end_key) begin
            state_d   = song_on_d ? ST_SONG_GAP : ST_IDLE;
            tone_en_d = 1'b0;
            enter     = 1'b1;
        end
        if (enter) begin
            pre_d   = '0;
            ticks_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            ticks_q    <= 12'd0;
            len_q      <= 12'd1;
            tone_en_q  <= 1'b0;
            tone_div_q <= '0;
            song_on_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            ticks_q    <= ticks_d;
            len_q      <= len_d;
            tone_en_q  <= tone_en_d;
            tone_div_q <= tone_div_d;
            song_on_q  <= song_on_d;
        end
    end

    assign song_ready = song_take;
    assign tone_en    = tone_en_q;
    assign tone_div   = tone_div_q;
    assign song_on    = song_on_q;
    assign play_src   = state_q;

endmodule
`default_nettype wire
